lsu_mem_initiator: RTL and testbench

Load/store initiator that turns single RV32 load/store requests from the core pipeline into transactions on the valid/ready memory bus consumed by `mem_controller` and `ram`. It aligns store data, generates byte enables, holds the request stable until accepted, and waits for read data. It sign- or zero-extends load results and returns one response per request. It sits between the execute/memory stage and the memory controller, as the initiator end of the bus that those blocks respond on.

---
 rtl/hidamari_mem_pkg.sv | 32 +++
 rtl/load_extend.sv | 32 +++
 rtl/lsu_mem_initiator.sv | 164 ++++++++++++++++
 tb/tb_lsu_mem_initiator.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/hidamari_mem_pkg.sv
// rtl/hidamari_mem_pkg.sv - shared memory-bus types, funct3 codes and lane helpers
package hidamari_mem_pkg;

    // RV32 load/store width codes (funct3)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_RDATA = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_t;

    // Byte-lane enables for an access of the given width at the given
    // in-word offset. Illegal widths enable nothing.
    function automatic logic [3:0] byte_en_for(input logic [2:0] funct3,
                                               input logic [1:0] addr_lo);
        logic [3:0] be;
        case (funct3)
            F3_B, F3_BU: be = 4'b0001 << addr_lo;
            F3_H, F3_HU: be = 4'b0011 << addr_lo;
            F3_W:        be = 4'b1111;
            default:     be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - load lane select plus sign/zero extension
//   rdata   : full 32-bit word read from memory
//   addr_lo : byte offset of the access within the word
//   funct3  : RV32 load width code
//   data    : LSB-justified, extended load result (0 for illegal codes)
module load_extend
    import hidamari_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] lane;

    // Bring the addressed byte/halfword down to bit 0
    assign lane = rdata >> {addr_lo, 3'b000};

    always_comb begin
        data = '0;
        case (funct3)
            F3_B:    data = {{24{lane[7]}}, lane[7:0]};
            F3_H:    data = {{16{lane[15]}}, lane[15:0]};
            F3_W:    data = lane;
            F3_BU:   data = {24'd0, lane[7:0]};
            F3_HU:   data = {16'd0, lane[15:0]};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// rtl/lsu_mem_initiator.sv - RV32 load/store to valid/ready memory-bus initiator
//   clk, rst            : clock, synchronous active-high reset
//   req_*               : single load/store request from the pipeline
//   resp_*              : one-cycle response pulse with extended load data / error
//   mem_*_out           : bus command, held stable while mem_valid_out until mem_ready_in
//   mem_rdata_valid_in,
//   mem_read_data_in    : read data return, honoured only while waiting for it
module lsu_mem_initiator
    import hidamari_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic        req_is_store_in,
    input  logic [2:0]  req_funct3_in,
    input  logic [31:0] req_addr_in,
    input  logic [31:0] req_wdata_in,
    output logic        resp_valid_out,
    output logic [31:0] resp_rdata_out,
    output logic        resp_error_out,
    output logic [31:0] mem_addr_out,
    output logic [31:0] mem_write_data_out,
    output logic [3:0]  mem_write_byte_en_out,
    output logic        mem_read_en_out,
    output logic        mem_write_en_out,
    output logic        mem_valid_out,
    input  logic        mem_ready_in,
    input  logic        mem_rdata_valid_in,
    input  logic [31:0] mem_read_data_in
);

    localparam int         TW         = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    lsu_state_t  state_q, state_d;
    logic [TW-1:0] timer_q;

    logic [2:0]  f3_q;
    logic [1:0]  addr_lo_q;
    logic        is_store_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_be_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;

    logic        req_illegal;
    logic        req_misaligned;
    logic        req_bad;
    logic        timer_expired;
    logic [31:0] wdata_lanes;
    logic [31:0] load_data;

    // Request checks on the incoming (not yet registered) request
    always_comb begin
        req_illegal    = 1'b0;
        req_misaligned = 1'b0;
        case (req_funct3_in)
            F3_B, F3_BU: ;
            F3_H, F3_HU: req_misaligned = req_addr_in[0];
            F3_W:        req_misaligned = (req_addr_in[1:0] != 2'b00);
            default:     req_illegal = 1'b1;
        endcase
    end

    assign req_bad = req_illegal || req_misaligned;

    // Replicate narrow store data across all lanes so the enables pick it out
    always_comb begin
        wdata_lanes = req_wdata_in;
        case (req_funct3_in)
            F3_B, F3_BU: wdata_lanes = {4{req_wdata_in[7:0]}};
            F3_H, F3_HU: wdata_lanes = {2{req_wdata_in[15:0]}};
            default:     wdata_lanes = req_wdata_in;
        endcase
    end

    load_extend u_load_extend (
        .rdata   (mem_read_data_in),
        .addr_lo (addr_lo_q),
        .funct3  (f3_q),
        .data    (load_data)
    );

    assign timer_expired = (timer_q == TIMER_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_in) state_d = req_bad ? ST_RESP : ST_REQ;
            end
            ST_REQ: begin
                // Acceptance wins over a timeout landing on the same cycle
                if (mem_ready_in)       state_d = is_store_q ? ST_RESP : ST_RDATA;
                else if (timer_expired) state_d = ST_RESP;
            end
            ST_RDATA: begin
                if (mem_rdata_valid_in || timer_expired) state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            f3_q         <= '0;
            addr_lo_q    <= '0;
            is_store_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            // Counter restarts on every state change, so it measures time
            // spent waiting in REQ or RDATA
            timer_q <= (state_d != state_q) ? '0 : timer_q + 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (req_valid_in) begin
                        f3_q         <= req_funct3_in;
                        addr_lo_q    <= req_addr_in[1:0];
                        is_store_q   <= req_is_store_in;
                        mem_addr_q   <= {req_addr_in[31:2], 2'b00};
                        mem_wdata_q  <= wdata_lanes;
                        mem_be_q     <= byte_en_for(req_funct3_in, req_addr_in[1:0]);
                        resp_rdata_q <= '0;
                        resp_err_q   <= req_bad;
                    end
                end
                ST_REQ: begin
                    if (!mem_ready_in && timer_expired) resp_err_q <= 1'b1;
                end
                ST_RDATA: begin
                    if (mem_rdata_valid_in)  resp_rdata_q <= load_data;
                    else if (timer_expired)  resp_err_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Bus and response fields read as zero outside the states that own them
    assign req_ready_out         = (state_q == ST_IDLE);
    assign mem_valid_out         = (state_q == ST_REQ);
    assign mem_addr_out          = mem_valid_out ? mem_addr_q  : '0;
    assign mem_write_data_out    = mem_valid_out ? mem_wdata_q : '0;
    assign mem_write_byte_en_out = mem_valid_out ? mem_be_q    : '0;
    assign mem_read_en_out       = mem_valid_out && !is_store_q;
    assign mem_write_en_out      = mem_valid_out && is_store_q;
    assign resp_valid_out        = (state_q == ST_RESP);
    assign resp_rdata_out        = resp_valid_out ? resp_rdata_q : '0;
    assign resp_error_out        = resp_valid_out && resp_err_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// tb/tb_lsu_mem_initiator.sv - directed self-checking bench for lsu_mem_initiator
module tb_lsu_mem_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_in;
    logic        req_ready_out;
    logic        req_is_store_in;
    logic [2:0]  req_funct3_in;
    logic [31:0] req_addr_in;
    logic [31:0] req_wdata_in;
    logic        resp_valid_out;
    logic [31:0] resp_rdata_out;
    logic        resp_error_out;
    logic [31:0] mem_addr_out;
    logic [31:0] mem_write_data_out;
    logic [3:0]  mem_write_byte_en_out;
    logic        mem_read_en_out;
    logic        mem_write_en_out;
    logic        mem_valid_out;
    logic        mem_ready_in;
    logic        mem_rdata_valid_in;
    logic [31:0] mem_read_data_in;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    lsu_mem_initiator #(.TIMEOUT_CYCLES(8)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .req_valid_in          (req_valid_in),
        .req_ready_out         (req_ready_out),
        .req_is_store_in       (req_is_store_in),
        .req_funct3_in         (req_funct3_in),
        .req_addr_in           (req_addr_in),
        .req_wdata_in          (req_wdata_in),
        .resp_valid_out        (resp_valid_out),
        .resp_rdata_out        (resp_rdata_out),
        .resp_error_out        (resp_error_out),
        .mem_addr_out          (mem_addr_out),
        .mem_write_data_out    (mem_write_data_out),
        .mem_write_byte_en_out (mem_write_byte_en_out),
        .mem_read_en_out       (mem_read_en_out),
        .mem_write_en_out      (mem_write_en_out),
        .mem_valid_out         (mem_valid_out),
        .mem_ready_in          (mem_ready_in),
        .mem_rdata_valid_in    (mem_rdata_valid_in),
        .mem_read_data_in      (mem_read_data_in)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present a request in cycle T; returns observing cycle T+1
    task automatic issue(input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        req_valid_in    = 1'b1;
        req_is_store_in = st;
        req_funct3_in   = f3;
        req_addr_in     = addr;
        req_wdata_in    = wd;
        tick();
        req_valid_in    = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_ready"},  {31'd0, req_ready_out}, 32'd1);
        chk({tag, "_resp"},   {31'd0, resp_valid_out}, 32'd0);
        chk({tag, "_mvalid"}, {31'd0, mem_valid_out}, 32'd0);
        chk({tag, "_maddr"},  mem_addr_out, 32'd0);
        chk({tag, "_mbe"},    {28'd0, mem_write_byte_en_out}, 32'd0);
        chk({tag, "_rdata"},  resp_rdata_out, 32'd0);
        chk({tag, "_err"},    {31'd0, resp_error_out}, 32'd0);
    endtask

    // Load with zero-wait bus and read data one cycle after bus acceptance
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] word, input logic [31:0] exp);
        mem_ready_in = 1'b1;
        issue(1'b0, f3, addr, 32'h0);
        chk({tag, "_mvalid"}, {31'd0, mem_valid_out}, 32'd1);
        chk({tag, "_rden"},   {31'd0, mem_read_en_out}, 32'd1);
        chk({tag, "_maddr"},  mem_addr_out, {addr[31:2], 2'b00});
        tick();
        chk({tag, "_mvalid_rd"}, {31'd0, mem_valid_out}, 32'd0);
        mem_rdata_valid_in = 1'b1;
        mem_read_data_in   = word;
        tick();
        mem_rdata_valid_in = 1'b0;
        mem_read_data_in   = 32'h0;
        chk({tag, "_resp"},  {31'd0, resp_valid_out}, 32'd1);
        chk({tag, "_data"},  resp_rdata_out, exp);
        chk({tag, "_err"},   {31'd0, resp_error_out}, 32'd0);
        tick();
        chk({tag, "_done"},  {31'd0, resp_valid_out}, 32'd0);
    endtask

    initial begin
        int n;
        logic seen_valid;

        rst = 1'b1;
        req_valid_in = 1'b0; req_is_store_in = 1'b0; req_funct3_in = 3'b0;
        req_addr_in = 32'h0; req_wdata_in = 32'h0;
        mem_ready_in = 1'b0; mem_rdata_valid_in = 1'b0; mem_read_data_in = 32'h0;
        tick(); tick();
        check_idle("reset");
        rst = 1'b0;
        tick();

        // Store W, zero-wait bus
        mem_ready_in = 1'b1;
        issue(1'b1, 3'b010, 32'h08, 32'hFFFF0000);
        chk("sw_mvalid", {31'd0, mem_valid_out}, 32'd1);
        chk("sw_maddr",  mem_addr_out, 32'h08);
        chk("sw_mbe",    {28'd0, mem_write_byte_en_out}, 32'hF);
        chk("sw_mdata",  mem_write_data_out, 32'hFFFF0000);
        chk("sw_wren",   {31'd0, mem_write_en_out}, 32'd1);
        chk("sw_rden",   {31'd0, mem_read_en_out}, 32'd0);
        chk("sw_ready",  {31'd0, req_ready_out}, 32'd0);
        chk("sw_noresp", {31'd0, resp_valid_out}, 32'd0);
        tick();
        chk("sw_resp",   {31'd0, resp_valid_out}, 32'd1);
        chk("sw_err",    {31'd0, resp_error_out}, 32'd0);
        chk("sw_mvalid2", {31'd0, mem_valid_out}, 32'd0);
        tick();
        chk("sw_idle",   {31'd0, req_ready_out}, 32'd1);
        chk("sw_single", {31'd0, resp_valid_out}, 32'd0);

        // Store B with three stall cycles: 4 valid cycles, stable fields
        mem_ready_in = 1'b0;
        issue(1'b1, 3'b000, 32'h0B, 32'h000000AB);
        for (int i = 0; i < 4; i++) begin
            chk("sb_mvalid", {31'd0, mem_valid_out}, 32'd1);
            chk("sb_maddr",  mem_addr_out, 32'h08);
            chk("sb_mbe",    {28'd0, mem_write_byte_en_out}, 32'h8);
            chk("sb_mdata",  mem_write_data_out, 32'hABABABAB);
            chk("sb_noresp", {31'd0, resp_valid_out}, 32'd0);
            if (i == 3) mem_ready_in = 1'b1;
            tick();
        end
        chk("sb_resp", {31'd0, resp_valid_out}, 32'd1);
        chk("sb_err",  {31'd0, resp_error_out}, 32'd0);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (resp_valid_out) n++;
        end
        chk("sb_single", n, 0);

        // Loads from word 0x80FF1234
        do_load("lh",  3'b001, 32'h0A, 32'h80FF1234, 32'hFFFF80FF);
        do_load("lhu", 3'b101, 32'h0A, 32'h80FF1234, 32'h000080FF);
        do_load("lb",  3'b000, 32'h09, 32'h80FF1234, 32'h00000012);
        do_load("lbs", 3'b000, 32'h0B, 32'h80FF1234, 32'hFFFFFF80);
        do_load("lbu", 3'b100, 32'h0B, 32'h80FF1234, 32'h00000080);
        do_load("lw",  3'b010, 32'h0C, 32'h80FF1234, 32'h80FF1234);

        // Misaligned word load: error at T+1, no bus traffic
        issue(1'b0, 3'b010, 32'h06, 32'h0);
        chk("mis_resp",   {31'd0, resp_valid_out}, 32'd1);
        chk("mis_err",    {31'd0, resp_error_out}, 32'd1);
        chk("mis_rdata",  resp_rdata_out, 32'd0);
        chk("mis_mvalid", {31'd0, mem_valid_out}, 32'd0);
        tick();
        chk("mis_mvalid2", {31'd0, mem_valid_out}, 32'd0);

        // Illegal funct3
        issue(1'b1, 3'b011, 32'h00, 32'h0);
        chk("ill_resp",   {31'd0, resp_valid_out}, 32'd1);
        chk("ill_err",    {31'd0, resp_error_out}, 32'd1);
        chk("ill_mvalid", {31'd0, mem_valid_out}, 32'd0);
        tick();

        // Read data never returns: 8 cycles in RDATA, response at T+10
        mem_ready_in = 1'b1;
        issue(1'b0, 3'b010, 32'h10, 32'h0);
        chk("to_mvalid", {31'd0, mem_valid_out}, 32'd1);
        n = 0;
        seen_valid = 1'b0;
        while (!resp_valid_out && n < 30) begin
            tick();
            n++;
            if (mem_valid_out) seen_valid = 1'b1;
        end
        chk("to_lat",     n, 9);
        chk("to_err",     {31'd0, resp_error_out}, 32'd1);
        chk("to_rdata",   resp_rdata_out, 32'd0);
        chk("to_nomvalid", {31'd0, seen_valid}, 32'd0);
        tick();

        // Bus never accepts: 8 cycles of REQ, response at T+9
        mem_ready_in = 1'b0;
        issue(1'b1, 3'b010, 32'h14, 32'h12345678);
        n = 0;
        while (!resp_valid_out && n < 30) begin
            tick();
            n++;
        end
        chk("toq_lat",    n, 8);
        chk("toq_err",    {31'd0, resp_error_out}, 32'd1);
        chk("toq_mvalid", {31'd0, mem_valid_out}, 32'd0);
        tick();

        // Reset while waiting for read data, then a late data pulse
        mem_ready_in = 1'b1;
        issue(1'b0, 3'b010, 32'h20, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("rst_mid");
        mem_rdata_valid_in = 1'b1;
        mem_read_data_in   = 32'hDEADBEEF;
        tick();
        mem_rdata_valid_in = 1'b0;
        chk("late_noresp", {31'd0, resp_valid_out}, 32'd0);
        chk("late_ready",  {31'd0, req_ready_out}, 32'd1);
        tick();
        chk("late_noresp2", {31'd0, resp_valid_out}, 32'd0);
        do_load("post_rst", 3'b001, 32'h22, 32'h7FFF0001, 32'h00007FFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
